wall_sprite_fetch: RTL

Pixel-pipeline stage that sits directly upstream of the wall sprite frame RAM and directly downstream of it on the read side. It converts the VGA scan position into a sprite RAM read address and consumes the palette index the RAM returns. It resolves that index through a fixed 4-entry palette into 24-bit RGB with a hit flag for the colour mapper. It also latches the wall origin once per frame and counts opaque wall pixels per frame for collision logic.

---
 rtl/wall_pkg.sv | 13 +
 rtl/wall_addr_gen.sv | 102 ++++++++++
 rtl/wall_sprite_fetch.sv | 97 +++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared sprite geometry, palette types and the fixed 4-entry wall palette.
package wall_pkg;

  localparam int unsigned SPRITE_W = 48;
  localparam int unsigned SPRITE_H = 44;

  typedef logic [1:0]  pal_idx_t;
  typedef logic [23:0] rgb_t;

  // Index 0 is transparent and never drawn.
  localparam rgb_t PALETTE [4] = '{24'h000000, 24'h5A3A1E, 24'hA0A0A0, 24'hFFFFFF};

endpackage

// File: rtl/wall_addr_gen.sv
// Wall origin shadow registers and Stage A: scan position -> sprite RAM address.
// Horizontal mirroring is only built when WALL_FLIP_EN is defined.
module wall_addr_gen #(
  parameter int unsigned SPRITE_W = wall_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H = wall_pkg::SPRITE_H
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  wall_x,
  input  logic [9:0]  wall_y,
  input  logic        flip_h,
  output logic [18:0] read_address,
  output logic        in_box_a,
  output logic        pix_valid_a
);

  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);

  logic [9:0]         org_x_q, org_x_d;
  logic [9:0]         org_y_q, org_y_d;
  logic               flip_s;
  logic signed [10:0] dx, dy;
  logic               dx_ok, dy_ok, in_box;
  logic [CW-1:0]      col;
  logic [18:0]        row_base;
  logic [18:0]        read_address_q, read_address_d;
  logic               in_box_q, in_box_d;
  logic               pix_valid_q, pix_valid_d;

`ifdef WALL_FLIP_EN
  logic flip_s_q, flip_s_d;

  always_comb begin
    flip_s_d = frame_start ? flip_h : flip_s_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) flip_s_q <= 1'b0;
    else          flip_s_q <= flip_s_d;
  end

  assign flip_s = flip_s_q;
`else
  logic unused_flip_h;
  assign unused_flip_h = flip_h;
  assign flip_s        = 1'b0;
`endif

  always_comb begin
    // Shadows update at the edge, so a pixel sharing the frame_start cycle still sees the old origin.
    org_x_d = frame_start ? wall_x : org_x_q;
    org_y_d = frame_start ? wall_y : org_y_q;

    dx    = 11'({1'b0, DrawX}) - 11'({1'b0, org_x_q});
    dy    = 11'({1'b0, DrawY}) - 11'({1'b0, org_y_q});
    dx_ok = !dx[10] && (dx[9:0] < 10'(SPRITE_W));
    dy_ok = !dy[10] && (dy[9:0] < 10'(SPRITE_H));
    in_box = pix_valid && dx_ok && dy_ok;

`ifdef WALL_FLIP_EN
    col = flip_s ? (CW'(SPRITE_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
`else
    col = flip_s ? '0 : dx[CW-1:0];
`endif

    // Constant multiply dy*SPRITE_W as a sum of shifted copies.
    row_base = '0;
    for (int unsigned b = 0; b < 19; b++) begin
      if (SPRITE_W[b]) row_base = row_base + (19'(dy[RW-1:0]) << b);
    end

    read_address_d = in_box ? (row_base + 19'(col)) : '0;
    in_box_d       = in_box;
    pix_valid_d    = pix_valid;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      org_x_q        <= '0;
      org_y_q        <= '0;
      read_address_q <= '0;
      in_box_q       <= 1'b0;
      pix_valid_q    <= 1'b0;
    end else begin
      org_x_q        <= org_x_d;
      org_y_q        <= org_y_d;
      read_address_q <= read_address_d;
      in_box_q       <= in_box_d;
      pix_valid_q    <= pix_valid_d;
    end
  end

  assign read_address = read_address_q;
  assign in_box_a     = in_box_q;
  assign pix_valid_a  = pix_valid_q;

endmodule

// File: rtl/wall_sprite_fetch.sv
// Wall sprite fetch: address generation, palette resolve (Stage B) and per-frame opaque pixel count.
// Optional macro WALL_FLIP_EN enables horizontal mirroring via flip_h.
module wall_sprite_fetch #(
  parameter int unsigned SPRITE_W = wall_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H = wall_pkg::SPRITE_H
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  wall_x,
  input  logic [9:0]  wall_y,
  input  logic        flip_h,
  output logic [18:0] read_address,
  input  logic [4:0]  ram_data,
  output logic [23:0] rgb,
  output logic        hit,
  output logic        rgb_valid,
  output logic [11:0] hit_count
);

  import wall_pkg::*;

  logic       in_box_a, pix_valid_a;
  logic       in_box_d_q, in_box_d_d;
  logic       pix_valid_d_q, pix_valid_d_d;
  pal_idx_t   idx;
  rgb_t       rgb_q, rgb_d;
  logic       hit_q, hit_d;
  logic       rgb_valid_q, rgb_valid_d;
  logic [11:0] acc_q, acc_d, acc_base;
  logic [11:0] hit_count_q, hit_count_d;
  logic [2:0] unused_ram_hi;

  assign unused_ram_hi = ram_data[4:2];

  wall_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_addr_gen (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .wall_x       (wall_x),
    .wall_y       (wall_y),
    .flip_h       (flip_h),
    .read_address (read_address),
    .in_box_a     (in_box_a),
    .pix_valid_a  (pix_valid_a)
  );

  always_comb begin
    in_box_d_d    = in_box_a;
    pix_valid_d_d = pix_valid_a;

    idx         = ram_data[1:0];
    hit_d       = in_box_d_q && (idx != 2'd0);
    rgb_d       = hit_d ? PALETTE[idx] : '0;
    rgb_valid_d = pix_valid_d_q;

    // A hit landing on the frame_start cycle belongs to the new frame.
    hit_count_d = frame_start ? acc_q : hit_count_q;
    acc_base    = frame_start ? '0 : acc_q;
    acc_d       = (hit_q && (acc_base != '1)) ? acc_base + 12'd1 : acc_base;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_box_d_q    <= 1'b0;
      pix_valid_d_q <= 1'b0;
      rgb_q         <= '0;
      hit_q         <= 1'b0;
      rgb_valid_q   <= 1'b0;
      acc_q         <= '0;
      hit_count_q   <= '0;
    end else begin
      in_box_d_q    <= in_box_d_d;
      pix_valid_d_q <= pix_valid_d_d;
      rgb_q         <= rgb_d;
      hit_q         <= hit_d;
      rgb_valid_q   <= rgb_valid_d;
      acc_q         <= acc_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign rgb       = rgb_q;
  assign hit       = hit_q;
  assign rgb_valid = rgb_valid_q;
  assign hit_count = hit_count_q;

endmodule
